pipelined_custom_adder: RTL and testbench

PIPELINED_CUSTOM_ADDER -- requirements
Module: pipelined_custom_adder

---
 rtl/pipelined_custom_adder.sv | 118 +++++++++++
 tb/tb_pipelined_custom_adder.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/pipelined_custom_adder.sv
// rtl/pipelined_custom_adder.sv - segmented carry-chain adder with valid/ready pipeline
module pipelined_custom_adder #(
    parameter int A_WIDTH    = 44,
    parameter int B_WIDTH    = 13,
    parameter int NUM_STAGES = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [A_WIDTH-1:0] a,
    input  logic [B_WIDTH-1:0] b,
    input  logic               b_signed,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [A_WIDTH:0]   sum
);

    // Segment width; trailing stages may be empty when the division is uneven.
    localparam int SEG = (A_WIDTH + NUM_STAGES - 1) / NUM_STAGES;

    logic               adv;
    logic [A_WIDTH-1:0] b_ext;

    // Extend b to operand width according to the beat's signedness flag
    always_comb begin
        if (b_signed) begin
            b_ext = A_WIDTH'($signed(b));
        end else begin
            b_ext = A_WIDTH'(b);
        end
    end

    // Whole pipeline moves together unless the output beat is stalled
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    for (genvar s = 0; s < NUM_STAGES; s++) begin : g_stage
        localparam int LO = (s * SEG < A_WIDTH) ? s * SEG : A_WIDTH;
        localparam int HI = (LO + SEG < A_WIDTH) ? LO + SEG : A_WIDTH;
        localparam int W  = HI - LO;       // bits added in this stage
        localparam int IW = A_WIDTH - LO;  // unprocessed operand bits arriving
        localparam int OW = A_WIDTH - HI;  // unprocessed operand bits leaving

        logic            v_in;
        logic            v_q;
        logic            c_d;
        logic            c_q;
        logic [HI-1:0]   s_d;
        logic [HI-1:0]   s_q;

        if (s == 0) begin : g_vfirst
            assign v_in = in_valid;
        end else begin : g_vnext
            assign v_in = g_stage[s-1].v_q;
        end

        if (W > 0) begin : g_work
            logic [IW-1:0] a_src;
            logic [IW-1:0] b_src;
            logic          c_in;
            logic [W:0]    seg_add;

            if (s == 0) begin : g_src
                assign a_src = a;
                assign b_src = b_ext;
                assign c_in  = 1'b0;
                assign s_d   = seg_add[W-1:0];
            end else begin : g_src
                assign a_src = g_stage[s-1].g_work.g_up.a_up_q;
                assign b_src = g_stage[s-1].g_work.g_up.b_up_q;
                assign c_in  = g_stage[s-1].c_q;
                assign s_d   = {seg_add[W-1:0], g_stage[s-1].s_q};
            end

            assign seg_add = {1'b0, a_src[W-1:0]} + {1'b0, b_src[W-1:0]} + {{W{1'b0}}, c_in};
            assign c_d     = seg_add[W];

            if (OW > 0) begin : g_up
                logic [OW-1:0] a_up_q;
                logic [OW-1:0] b_up_q;

                // Carry the not-yet-added operand bits along with the beat
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        a_up_q <= '0;
                        b_up_q <= '0;
                    end else if (adv && v_in) begin
                        a_up_q <= a_src[IW-1:W];
                        b_up_q <= b_src[IW-1:W];
                    end
                end
            end
        end else begin : g_pass
            assign s_d = g_stage[s-1].s_q;
            assign c_d = g_stage[s-1].c_q;
        end

        // Stage register: valid bit always advances, data only for real beats
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                v_q <= 1'b0;
                c_q <= 1'b0;
                s_q <= '0;
            end else if (adv) begin
                v_q <= v_in;
                if (v_in) begin
                    c_q <= c_d;
                    s_q <= s_d;
                end
            end
        end
    end

    assign out_valid = g_stage[NUM_STAGES-1].v_q;
    assign sum       = {g_stage[NUM_STAGES-1].c_q, g_stage[NUM_STAGES-1].s_q};

endmodule

// File: tb/tb_pipelined_custom_adder.sv
// tb/tb_pipelined_custom_adder.sv - self-checking bench for pipelined_custom_adder
module tb_pipelined_custom_adder;

    localparam int AW = 44;
    localparam int BW = 13;
    localparam int NS = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [AW-1:0] a;
    logic [BW-1:0] b;
    logic          b_signed;
    logic          out_valid;
    logic          out_ready;
    logic [AW:0]   sum;

    int n_checks = 0;
    int n_errors = 0;

    logic [63:0] exp_q[$];
    int          rdy_bad  = 0;
    int          spurious = 0;

    always #5 clk = ~clk;

    pipelined_custom_adder #(
        .A_WIDTH   (AW),
        .B_WIDTH   (BW),
        .NUM_STAGES(NS)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .b_signed (b_signed),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .sum      (sum)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: integer value of extended b, wrapped to AW bits, added to a.
    function automatic logic [63:0] ref_sum(input logic [63:0] av, input logic [63:0] bv, input logic bs);
        longint      ext;
        logic [63:0] mask;
        ext = longint'(bv);
        if (bs && bv[BW-1]) ext = ext - (longint'(1) << BW);
        mask = (64'd1 << AW) - 64'd1;
        return av + (64'(ext) & mask);
    endfunction

    task automatic next_cycle(input logic iv, input logic [AW-1:0] av, input logic [BW-1:0] bv,
                              input logic bs, input logic ordy);
        @(negedge clk);
        in_valid  = iv;
        a         = av;
        b         = bv;
        b_signed  = bs;
        out_ready = ordy;
        #1;
    endtask

    task automatic idle_cycle(input logic ordy);
        next_cycle(1'b0, AW'({$urandom, $urandom}), BW'($urandom), 1'($urandom), ordy);
    endtask

    task automatic send_one(input string tag, input logic [AW-1:0] av, input logic [BW-1:0] bv,
                            input logic bs, input logic [63:0] exp);
        int lat;
        next_cycle(1'b1, av, bv, bs, 1'b1);
        check_eq({tag, "_accept"}, 64'(in_ready), 64'd1);
        for (lat = 1; lat <= 20; lat++) begin
            idle_cycle(1'b1);
            if (out_valid) break;
        end
        check_eq({tag, "_latency"}, 64'(lat), 64'(NS));
        check_eq({tag, "_sum"}, 64'(sum), exp);
    endtask

    task automatic score();
        if (in_ready !== (!out_valid || out_ready)) rdy_bad++;
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) spurious++;
            else check_eq("rand_sum", 64'(sum), exp_q.pop_front());
        end
        if (in_valid && in_ready) exp_q.push_back(ref_sum(64'(a), 64'(b), b_signed));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int got;
        int stale;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        b_signed  = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check_eq("reset_out_valid", 64'(out_valid), 64'd0);
        check_eq("reset_sum", 64'(sum), 64'd0);
        rst_n = 1'b1;
        idle_cycle(1'b1);
        check_eq("reset_in_ready", 64'(in_ready), 64'd1);

        send_one("zext_carry", 44'hFFF_FFFF_FFFF, 13'h0001, 1'b0, 64'h1000_0000_0000);
        send_one("sext", 44'h000_0000_0010, 13'h1FFF, 1'b1, 64'h1000_0000_000F);
        send_one("sext_off", 44'h000_0000_0010, 13'h1FFF, 1'b0, 64'h000_0000_200F);
        send_one("seg_carry", 44'h000_0000_07FF, 13'h0001, 1'b0, 64'h000_0000_0800);

        // Backpressure: four back-to-back beats, then stall three cycles
        for (int i = 0; i < 4; i++) next_cycle(1'b1, '0, BW'(i + 1), 1'b0, 1'b1);
        for (int k = 0; k < 3; k++) begin
            idle_cycle(1'b0);
            check_eq("bp_in_ready", 64'(in_ready), 64'd0);
            check_eq("bp_valid_hold", 64'(out_valid), 64'd1);
            check_eq("bp_sum_hold", 64'(sum), 64'd1);
        end
        got = 0;
        for (int cyc = 0; cyc < 20 && got < 4; cyc++) begin
            idle_cycle(1'b1);
            if (out_valid) begin
                check_eq("bp_order", 64'(sum), 64'(got + 1));
                got++;
            end
        end
        check_eq("bp_count", 64'(got), 64'd4);
        for (int k = 0; k < 4; k++) idle_cycle(1'b1);

        // Reset while three beats are in flight
        for (int i = 0; i < 3; i++) next_cycle(1'b1, AW'(i + 5), BW'(i + 1), 1'b0, 1'b1);
        idle_cycle(1'b1);
        idle_cycle(1'b0);
        check_eq("rst_mid_pre_valid", 64'(out_valid), 64'd1);
        rst_n = 1'b0;
        #1;
        check_eq("rst_mid_valid", 64'(out_valid), 64'd0);
        check_eq("rst_mid_sum", 64'(sum), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        stale = 0;
        for (int k = 0; k < 8; k++) begin
            idle_cycle(1'b1);
            if (out_valid) stale++;
        end
        check_eq("rst_no_stale", 64'(stale), 64'd0);
        send_one("rst_after", 44'h123_4567_89AB, 13'h0F00, 1'b1, 64'h123_4567_98AB);

        // Randomized traffic against the scoreboard
        for (int i = 0; i < 3000; i++) begin
            next_cycle(1'($urandom_range(0, 9) < 7), AW'({$urandom, $urandom}), BW'($urandom),
                       1'($urandom), 1'($urandom_range(0, 9) < 7));
            score();
        end
        for (int i = 0; i < 100 && (exp_q.size() != 0 || out_valid); i++) begin
            idle_cycle(1'b1);
            score();
        end
        check_eq("rand_drained", 64'(exp_q.size()), 64'd0);
        check_eq("rand_spurious", 64'(spurious), 64'd0);
        check_eq("rand_in_ready_rule", 64'(rdy_bad), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
